// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt collector for up to seven sources behind a 65xx-style
// chip-select register port: one mask-write / flag-read register, active-low IRQ out.
module irq_ctrl #(
  parameter int NUM_SRC = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_cs,
  input  logic               i_rw,
  input  logic [7:0]         i_data,
  input  logic [NUM_SRC-1:0] i_src,
  output logic [7:0]         o_data,
  output logic               o_irq_n
);

  logic               r_cs_prev;
  logic [NUM_SRC-1:0] r_src_prev;
  logic [NUM_SRC-1:0] r_flag;
  logic [NUM_SRC-1:0] r_mask;
  logic [7:0]         r_data;
  logic               r_irq_n;

  logic               w_access;
  logic               w_rd;
  logic               w_wr;
  logic [NUM_SRC-1:0] w_event;
  logic [NUM_SRC-1:0] w_flag_next;
  logic [NUM_SRC-1:0] w_mask_next;
  logic               w_ir_now;
  logic               w_ir_next;
  logic [7:0]         w_rd_word;
  logic [7:0]         w_data_next;

  // One access per falling edge of chip select; holding it low does nothing more.
  assign w_access = ~i_cs & r_cs_prev;
  assign w_rd     = w_access & i_rw;
  assign w_wr     = w_access & ~i_rw;
  assign w_event  = i_src & ~r_src_prev;

  always_comb begin
    w_mask_next = r_mask;
    if (w_wr) begin
      if (i_data[7]) begin
        w_mask_next = r_mask | i_data[NUM_SRC-1:0];
      end else begin
        w_mask_next = r_mask & ~i_data[NUM_SRC-1:0];
      end
    end
  end

  // A read clears everything except events landing in the read cycle itself.
  assign w_flag_next = w_rd ? w_event : (r_flag | w_event);
  assign w_ir_now    = |(r_flag & r_mask);
  assign w_ir_next   = |(w_flag_next & w_mask_next);

  always_comb begin
    w_rd_word              = 8'h00;
    w_rd_word[NUM_SRC-1:0] = r_flag;
    w_rd_word[7]           = w_ir_now;
  end

  always_comb begin
    w_data_next = r_data;
    if (i_cs) begin
      w_data_next = 8'h00;
    end else if (w_rd) begin
      w_data_next = w_rd_word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cs_prev  <= 1'b1;
      r_src_prev <= i_src;
      r_flag     <= '0;
      r_mask     <= '0;
      r_data     <= 8'h00;
      r_irq_n    <= 1'b1;
    end else begin
      r_cs_prev  <= i_cs;
      r_src_prev <= i_src;
      r_flag     <= w_flag_next;
      r_mask     <= w_mask_next;
      r_data     <= w_data_next;
      r_irq_n    <= ~w_ir_next;
    end
  end

  assign o_data  = r_data;
  assign o_irq_n = r_irq_n;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed scoreboard bench for irq_ctrl: stimulus queues the expected register/IRQ
// state for a given cycle, a negedge monitor pops and compares.
module tb_irq_ctrl;

  localparam int NUM_SRC = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               cs;
  logic               rw;
  logic [7:0]         wdata;
  logic [NUM_SRC-1:0] src;
  logic [7:0]         rdata;
  logic               irq_n;

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] data;
    logic       irq_n;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc    = 0;
  int   npass  = 0;
  int   ntotal = 0;

  irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_cs    (cs),
    .i_rw    (rw),
    .i_data  (wdata),
    .i_src   (src),
    .o_data  (rdata),
    .o_irq_n (irq_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      ntotal++;
      if (e.cyc != cyc) begin
        $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
      end else if (rdata !== e.data || irq_n !== e.irq_n) begin
        $display("FAIL %s: o_data=%02h o_irq_n=%b, required o_data=%02h o_irq_n=%b",
                 e.name, rdata, irq_n, e.data, e.irq_n);
      end else begin
        npass++;
        $display("ok   %s: o_data=%02h o_irq_n=%b", e.name, rdata, irq_n);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect this state right after the next rising edge.
  task automatic expect_next(input string name, input logic [7:0] d, input logic irq);
    exp_t x;
    x.cyc   = cyc + 1;
    x.name  = name;
    x.data  = d;
    x.irq_n = irq;
    q.push_back(x);
  endtask

  task automatic do_read(input string name, input logic [7:0] d, input logic irq_after);
    cs = 1'b0;
    rw = 1'b1;
    expect_next(name, d, irq_after);
    tick();
    cs = 1'b1;
    expect_next({name, "_rel"}, 8'h00, irq_after);
    tick();
  endtask

  task automatic do_write(input string name, input logic [7:0] d, input logic irq_after);
    cs    = 1'b0;
    rw    = 1'b0;
    wdata = d;
    expect_next(name, 8'h00, irq_after);
    tick();
    cs = 1'b1;
    expect_next({name, "_rel"}, 8'h00, irq_after);
    tick();
  endtask

  task automatic pulse(input int k, input string name, input logic irq_at_edge);
    src[k] = 1'b1;
    expect_next(name, 8'h00, irq_at_edge);
    tick();
    src[k] = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; rw = 1'b1; wdata = 8'h00; src = '0;
    expect_next("reset", 8'h00, 1'b1);
    tick();
    tick();
    rst = 1'b0;

    // Unmasked event: flag only, no IRQ.
    pulse(0, "unmasked_ev", 1'b1);
    do_read("unmasked_rd1", 8'h01, 1'b1);
    do_read("unmasked_rd2", 8'h00, 1'b1);

    // Masked event then read-clear.
    do_write("mask_w81", 8'h81, 1'b1);
    pulse(0, "masked_ev", 1'b0);
    do_read("masked_rd", 8'h81, 1'b1);

    // Pending flag enabled later, then disabled again.
    pulse(1, "pend_ev", 1'b1);
    do_write("pend_en_w82", 8'h82, 1'b0);
    do_write("pend_dis_w02", 8'h02, 1'b1);
    do_read("pend_rd", 8'h02, 1'b1);

    // Read colliding with a new event on the same source.
    pulse(0, "coll_ev", 1'b0);
    src[0] = 1'b1;
    do_read("coll_rd", 8'h81, 1'b0);
    src[0] = 1'b0;
    do_read("coll_rd2", 8'h81, 1'b1);

    // Chip select held low: one clear only; a re-event mid-hold must survive.
    pulse(2, "hold_ev", 1'b1);
    cs = 1'b0; rw = 1'b1;
    expect_next("hold_c1", 8'h04, 1'b1);
    tick();
    src[2] = 1'b1;
    expect_next("hold_c2", 8'h04, 1'b1);
    tick();
    src[2] = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      expect_next($sformatf("hold_c%0d", i), 8'h04, 1'b1);
      tick();
    end
    cs = 1'b1;
    expect_next("hold_rel", 8'h00, 1'b1);
    tick();
    do_read("hold_rd2", 8'h04, 1'b1);

    // Reset while pending with a source held high.
    do_write("rst_w88", 8'h88, 1'b1);
    src[3] = 1'b1;
    expect_next("rst_pend", 8'h00, 1'b0);
    tick();
    rst = 1'b1;
    expect_next("rst_mid", 8'h00, 1'b1);
    tick();
    rst = 1'b0;
    expect_next("rst_after", 8'h00, 1'b1);
    tick();
    do_read("rst_rd", 8'h00, 1'b1);
    do_write("rst_w88b", 8'h88, 1'b1);
    src[3] = 1'b0;
    expect_next("rst_src_low", 8'h00, 1'b1);
    tick();
    src[3] = 1'b1;
    expect_next("rst_src_rise", 8'h00, 1'b0);
    tick();
    do_read("rst_rd2", 8'h88, 1'b1);
    src[3] = 1'b0;

    // Mask write coinciding with an event.
    src[2] = 1'b1;
    do_write("wr_ev_w84", 8'h84, 1'b0);
    src[2] = 1'b0;
    do_read("wr_ev_rd", 8'h84, 1'b1);

    tick();
    tick();
    if (q.size() != 0) begin
      ntotal += q.size();
      $display("FAIL drain: %0d expectations never checked, required 0", q.size());
    end
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter: NUM_SRC, default 5, number of interrupt sources (1..7).
REQ-002 i_clk  in  1  system clock; all state updates on rising edge.
REQ-003 i_reset  in  1  reset, synchronous, active-high.
REQ-004 i_cs  in  1  chip select, active-low (MOS 65xx convention).
REQ-005 i_rw  in  1  1 = read, 0 = write.
REQ-006 i_data  in  8  write data.
REQ-007 i_src  in  NUM_SRC  source lines, one per counter o_irq or other source; an event is a rising edge.
REQ-008 o_data  out  8  read data, registered.
REQ-009 o_irq_n  out  1  combined interrupt request, active-low, registered.

Function
REQ-010 Access: exactly one access SHALL occur per i_cs assertion, in the first cycle where i_cs=0 and i_cs was 1 in the previous cycle; further cycles with i_cs held low SHALL NOT repeat the access.
REQ-011 Edge detect: the block SHALL keep a registered copy of i_src; source k has an event in cycle N when i_src[k]=1 at edge N and was 0 at edge N-1.
REQ-012 Flags: an event SHALL set flag[k] at edge N, independent of the mask.
REQ-013 A set flag SHALL stay set until a read access clears it.
REQ-014 Mask write (i_rw=0): if i_data[7]=1, mask bits at positions where i_data[NUM_SRC-1:0]=1 SHALL be set. If i_data[7]=0, those mask bits SHALL be cleared. All other mask bits SHALL be unchanged.
REQ-015 Write data bits NUM_SRC..6 SHALL be ignored.
REQ-016 IR = |(flag & mask), computed from next-state values.
REQ-017 o_irq_n SHALL be registered as ~IR, so that o_irq_n goes low at the same edge at which the causing flag or mask bit becomes set.
REQ-018 Read (i_rw=0... i.e. i_rw=1): at the access edge, o_data SHALL load {IR, zeros, flag[NUM_SRC-1:0]} using the pre-access flag/IR values.
REQ-019 At the same edge, all flags SHALL clear and o_irq_n SHALL go high, except as required by REQ-021.
REQ-020 o_data SHALL hold its value while i_cs stays low, and SHALL be 0x00 in every cycle after an edge where i_cs=1.
REQ-021 Simultaneous read and event: a flag whose event occurs in the access cycle SHALL remain set after the clear. It SHALL NOT appear in that read's o_data. If it is masked-in, o_irq_n SHALL stay low.
REQ-022 Simultaneous mask write and event: the flag SHALL set and the new mask SHALL apply, so o_irq_n reflects flag & new mask at that edge.
REQ-023 Enabling a mask bit whose flag is already pending SHALL drive o_irq_n low at the write edge.
REQ-024 Clearing the last masked-in pending bit SHALL drive o_irq_n high at the write edge; the flag SHALL remain set.
REQ-025 A source held high SHALL produce exactly one event; a new event requires a return to 0.

Reset
REQ-026 While i_reset=1 at an edge, the following SHALL hold:
- flags = 0, mask = 0
- o_irq_n = 1, o_data = 0x00
- the access-detect history SHALL be set as if i_cs=1
- the i_src history SHALL load the current i_src, so a source already high at reset release does not raise an event
REQ-027 A reset during an access or a pending interrupt SHALL override it, and reset values SHALL hold in the following cycle.

Verification
REQ-028 Basic unmasked event: after reset, pulse i_src[0] 0->1 for one cycle. Required response:
- no o_irq_n assertion
- a subsequent read returns o_data=0x01
- a second read returns 0x00
REQ-029 Masked event and read-clear: write 0x81, then pulse i_src[0] at cycle N. Required response:
- o_irq_n low after edge N
- a read returns 0x81
- o_irq_n high after the read edge
REQ-030 Pending then enable: pulse i_src[1] with mask=0, then write 0x82. Required response:
- o_irq_n low at the write edge
- writing 0x02 returns o_irq_n high with flag[1] still set (next read returns 0x02)
REQ-031 Read/event collision: mask=0x01 with flag[0] set, read in the same cycle as an i_src[0] edge. Required response:
- o_data=0x81
- o_irq_n stays low
- the next read returns 0x81
REQ-032 Held chip select: hold i_cs low for 5 cycles with i_rw=1 and flag[2] set. Required response:
- a single clear occurs
- o_data=0x04 for all cycles while low
- o_data=0x00 after i_cs rises
REQ-033 Reset mid-pending: with o_irq_n low and i_src[3] held high, assert i_reset for one cycle. Required response:
- o_irq_n=1
- a read returns 0x00
- no event until i_src[3] falls and rises again
